out_seq_ctrl: RTL and testbench

OUT_SEQ_CTRL -- requirements
Module: out_seq_ctrl

---
 rtl/out_ctrl_pkg.sv | 18 +
 rtl/pattern_table.sv | 28 ++
 rtl/out_seq_ctrl.sv | 137 +++++++++++++
 tb/tb_out_seq_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/out_ctrl_pkg.sv
// Shared types for the output sequencer: FSM encoding, output mode record
// and the floor applied to a zero step length.
package out_ctrl_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } seq_state_e;

  typedef struct packed {
    logic sel_pwm;
    logic invert;
  } out_mode_t;

  // A step_len of zero still holds each entry for one cycle.
  localparam int STEP_MIN = 1;

endpackage

// File: rtl/pattern_table.sv
// DEPTH x W pattern storage: synchronous write, combinational read, async clear.
module pattern_table #(
  parameter int DEPTH = 8,
  parameter int W     = 7
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [W-1:0]             wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [W-1:0]             rd_data
);

  logic [DEPTH-1:0][W-1:0] mem;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem <= '0;
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read comes straight from the flops, so a same-cycle write is not visible.
  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/out_seq_ctrl.sv
// Pattern sequencer stepping through a small table at a programmable rate,
// plus an output-mode register that only changes on PWM period boundaries.
module out_seq_ctrl
  import out_ctrl_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int STEP_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [6:0]               wr_data,
  input  logic [STEP_W-1:0]        step_len,
  input  logic [$clog2(DEPTH)-1:0] last_idx,
  input  logic                     loop_en,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     req_valid,
  input  logic                     req_sel_pwm,
  input  logic                     req_invert,
  input  logic                     pwm_period_end,
  output logic [6:0]               ovalues,
  output logic                     sel_pwm,
  output logic                     invert_polarity,
  output logic                     busy,
  output logic [$clog2(DEPTH)-1:0] idx,
  output logic                     done,
  output logic                     mode_pending
);

  localparam int AW = $clog2(DEPTH);

  seq_state_e        state, state_n;
  logic [AW-1:0]     idx_n, rd_addr;
  logic [STEP_W-1:0] cnt, cnt_n, step_ld;
  logic [6:0]        rd_data;
  logic              ld_val, done_n;

  pattern_table #(.DEPTH(DEPTH), .W(7)) u_tbl (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  assign step_ld = (step_len == '0) ? STEP_W'(STEP_MIN) : step_len;
  assign busy    = (state == ST_RUN);

  // cnt holds the remaining cycles of the current entry; 1 means last cycle.
  // An index at or beyond last_idx (last_idx lowered mid-run) ends the pass.
  always_comb begin
    state_n = state;
    idx_n   = idx;
    cnt_n   = cnt;
    ld_val  = 1'b0;
    done_n  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start && !stop) begin
          state_n = ST_RUN;
          idx_n   = '0;
          cnt_n   = step_ld;
          ld_val  = 1'b1;
        end
      end
      ST_RUN: begin
        if (stop) begin
          state_n = ST_IDLE;
        end else if (cnt <= STEP_W'(1)) begin
          if (idx < last_idx) begin
            idx_n  = idx + 1'b1;
            cnt_n  = step_ld;
            ld_val = 1'b1;
          end else if (loop_en) begin
            idx_n  = '0;
            cnt_n  = step_ld;
            ld_val = 1'b1;
          end else begin
            state_n = ST_IDLE;
            cnt_n   = '0;
            done_n  = 1'b1;
          end
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
    rd_addr = idx_n;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      idx     <= '0;
      cnt     <= '0;
      done    <= 1'b0;
      ovalues <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      cnt   <= cnt_n;
      done  <= done_n;
      if (ld_val) ovalues <= rd_data;
    end
  end

  // Mode path: a request arriving with the boundary bypasses the pending slot;
  // with PWM deselected there is no boundary to wait for.
  out_mode_t cur_mode, pend_mode, req_mode;

  assign req_mode        = '{sel_pwm: req_sel_pwm, invert: req_invert};
  assign sel_pwm         = cur_mode.sel_pwm;
  assign invert_polarity = cur_mode.invert;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_mode     <= '0;
      pend_mode    <= '0;
      mode_pending <= 1'b0;
    end else if (req_valid && pwm_period_end) begin
      cur_mode     <= req_mode;
      mode_pending <= 1'b0;
    end else if (req_valid) begin
      pend_mode    <= req_mode;
      mode_pending <= 1'b1;
    end else if (mode_pending && (pwm_period_end || !cur_mode.sel_pwm)) begin
      cur_mode     <= pend_mode;
      mode_pending <= 1'b0;
    end
  end

endmodule

// File: tb/tb_out_seq_ctrl.sv
// Bench for out_seq_ctrl: directed vector table, hand-written corner cases and
// a randomized run, all cross-checked against a cycle-level reference model.
module tb_out_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [6:0]  wr_data;
  logic [15:0] step_len;
  logic [2:0]  last_idx;
  logic        loop_en, start, stop;
  logic        req_valid, req_sel_pwm, req_invert, pwm_period_end;
  logic [6:0]  ovalues;
  logic        sel_pwm, invert_polarity, busy, done, mode_pending;
  logic [2:0]  idx;

  int checks = 0;
  int errors = 0;

  out_seq_ctrl #(.DEPTH(8), .STEP_W(16)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .step_len(step_len), .last_idx(last_idx), .loop_en(loop_en),
    .start(start), .stop(stop), .req_valid(req_valid),
    .req_sel_pwm(req_sel_pwm), .req_invert(req_invert),
    .pwm_period_end(pwm_period_end), .ovalues(ovalues), .sel_pwm(sel_pwm),
    .invert_polarity(invert_polarity), .busy(busy), .idx(idx), .done(done),
    .mode_pending(mode_pending)
  );

  always #5 clk = ~clk;

  // Reference model: elapsed-cycle count per entry, plain array table.
  int m_tbl[8];
  int m_ov, m_idx, m_hold, m_el;
  bit m_run, m_done;
  bit m_sel, m_inv, m_pend, m_psel, m_pinv;

  task automatic model_reset();
    foreach (m_tbl[i]) m_tbl[i] = 0;
    m_ov = 0; m_idx = 0; m_hold = 0; m_el = 0;
    m_run = 0; m_done = 0;
    m_sel = 0; m_inv = 0; m_pend = 0; m_psel = 0; m_pinv = 0;
  endtask

  task automatic model_step();
    int old[8];
    int hl;
    old = m_tbl;
    hl = (step_len == 0) ? 1 : int'(step_len);
    m_done = 0;
    if (!m_run) begin
      if (start && !stop) begin
        m_run = 1; m_idx = 0; m_ov = old[0]; m_hold = hl; m_el = 1;
      end
    end else if (stop) begin
      m_run = 0;
    end else if (m_el < m_hold) begin
      m_el++;
    end else if (m_idx < int'(last_idx)) begin
      m_idx++; m_ov = old[m_idx]; m_hold = hl; m_el = 1;
    end else if (loop_en) begin
      m_idx = 0; m_ov = old[0]; m_hold = hl; m_el = 1;
    end else begin
      m_run = 0; m_done = 1;
    end
    if (wr_en) m_tbl[wr_addr] = int'(wr_data);

    if (req_valid && pwm_period_end) begin
      m_sel = req_sel_pwm; m_inv = req_invert; m_pend = 0;
    end else if (req_valid) begin
      m_psel = req_sel_pwm; m_pinv = req_invert; m_pend = 1;
    end else if (m_pend && (pwm_period_end || !m_sel)) begin
      m_sel = m_psel; m_inv = m_pinv; m_pend = 0;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_model();
    chk("ovalues", 32'(ovalues), 32'(m_ov));
    chk("idx", 32'(idx), 32'(m_idx));
    chk("busy", 32'(busy), 32'(m_run));
    chk("done", 32'(done), 32'(m_done));
    chk("sel_pwm", 32'(sel_pwm), 32'(m_sel));
    chk("invert_polarity", 32'(invert_polarity), 32'(m_inv));
    chk("mode_pending", 32'(mode_pending), 32'(m_pend));
  endtask

  task automatic clr_pulses();
    wr_en = 0; start = 0; stop = 0; req_valid = 0; pwm_period_end = 0;
  endtask

  // One clock: model advances on the same edge as the DUT, compare mid-cycle.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk_model();
    clr_pulses();
  endtask

  task automatic write_tbl(input int a, input int d);
    wr_en = 1; wr_addr = 3'(a); wr_data = 7'(d);
    tick();
  endtask

  typedef struct {
    logic       start, stop, loop_en;
    logic [6:0] ov;
    logic [2:0] idx;
    logic       busy, done;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic s, logic p, logic l, logic [6:0] o,
                              logic [2:0] i, logic b, logic d);
    vec_t v;
    v.start = s; v.stop = p; v.loop_en = l; v.ov = o; v.idx = i; v.busy = b; v.done = d;
    return v;
  endfunction

  initial begin
    // Non-looping pass: three entries of three cycles, then done.
    vecs.push_back(mk(1,0,0,7'h01,0,1,0));
    vecs.push_back(mk(0,0,0,7'h01,0,1,0));
    vecs.push_back(mk(0,0,0,7'h01,0,1,0));
    for (int k = 0; k < 3; k++) vecs.push_back(mk(0,0,0,7'h02,1,1,0));
    for (int k = 0; k < 3; k++) vecs.push_back(mk(0,0,0,7'h04,2,1,0));
    vecs.push_back(mk(0,0,0,7'h04,2,0,1));
    vecs.push_back(mk(0,0,0,7'h04,2,0,0));
    // Looping pass: 0x01 returns 9 cycles after the first load, then stop.
    for (int k = 0; k < 3; k++) vecs.push_back(mk(k == 0,0,1,7'h01,0,1,0));
    for (int k = 0; k < 3; k++) vecs.push_back(mk(0,0,1,7'h02,1,1,0));
    for (int k = 0; k < 3; k++) vecs.push_back(mk(0,0,1,7'h04,2,1,0));
    vecs.push_back(mk(0,0,1,7'h01,0,1,0));
    vecs.push_back(mk(0,0,1,7'h01,0,1,0));
    vecs.push_back(mk(0,1,1,7'h01,0,0,0));
    vecs.push_back(mk(1,1,1,7'h01,0,0,0));
    vecs.push_back(mk(0,0,1,7'h01,0,0,0));

    rst = 1; clr_pulses();
    wr_addr = 0; wr_data = 0; step_len = 3; last_idx = 2; loop_en = 0;
    req_sel_pwm = 0; req_invert = 0;
    model_reset();
    @(negedge clk); @(negedge clk);
    chk("rst_ovalues", 32'(ovalues), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_idx", 32'(idx), 0);
    chk("rst_mode", 32'({sel_pwm, invert_polarity, mode_pending, done}), 0);
    rst = 0;

    write_tbl(0, 7'h01); write_tbl(1, 7'h02); write_tbl(2, 7'h04);

    foreach (vecs[i]) begin
      start = vecs[i].start; stop = vecs[i].stop; loop_en = vecs[i].loop_en;
      tick();
      chk($sformatf("vec%0d_ov", i), 32'(ovalues), 32'(vecs[i].ov));
      chk($sformatf("vec%0d_idx", i), 32'(idx), 32'(vecs[i].idx));
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].busy));
      chk($sformatf("vec%0d_done", i), 32'(done), 32'(vecs[i].done));
    end

    // Stop on the fourth RUN cycle holds the second entry.
    loop_en = 0;
    start = 1; tick(); tick(); tick(); tick();
    chk("stop_pre_ov", 32'(ovalues), 32'h02);
    stop = 1; tick();
    chk("stop_busy", 32'(busy), 0);
    chk("stop_ov", 32'(ovalues), 32'h02);
    chk("stop_done", 32'(done), 0);

    // step_len = 0 behaves as one cycle per entry.
    step_len = 0; last_idx = 1;
    start = 1; tick();
    chk("s0_ov0", 32'(ovalues), 32'h01);
    tick();
    chk("s0_ov1", 32'(ovalues), 32'h02);
    tick();
    chk("s0_done", 32'({busy, done}), 32'b01);

    // Write and load of address 0 in one cycle loads the old value.
    start = 1; wr_en = 1; wr_addr = 0; wr_data = 7'h55; tick();
    chk("wr_ld_old", 32'(ovalues), 32'h01);
    stop = 1; tick();

    // Mode: with PWM off a request applies next cycle; with PWM on it waits.
    req_valid = 1; req_sel_pwm = 1; req_invert = 0; tick();
    chk("m_pend0", 32'(mode_pending), 1);
    tick();
    chk("m_sel_on", 32'({sel_pwm, mode_pending}), 32'b10);
    req_valid = 1; req_sel_pwm = 1; req_invert = 1; tick();
    chk("m_pend1", 32'(mode_pending), 1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("m_wait_inv", 32'(invert_polarity), 0);
    end
    pwm_period_end = 1; tick();
    chk("m_inv_on", 32'({invert_polarity, mode_pending}), 32'b10);
    req_valid = 1; req_sel_pwm = 1; req_invert = 0; pwm_period_end = 1; tick();
    chk("m_direct", 32'({invert_polarity, mode_pending}), 32'b00);

    // Reset while running at idx 1 clears everything immediately.
    step_len = 2; last_idx = 3; loop_en = 1;
    start = 1; tick();
    begin
      int guard = 0;
      while (m_idx != 1 && guard < 50) begin tick(); guard++; end
      chk("rst_wait_idx1", 32'(idx), 1);
    end
    rst = 1;
    #1;
    chk("mrst_outs", 32'({ovalues, idx, busy, done, sel_pwm, invert_polarity, mode_pending}), 0);
    model_reset();
    @(negedge clk);
    rst = 0;
    tick();
    chk("mrst_idle", 32'(busy), 0);
    start = 1; tick();
    chk("mrst_tbl0", 32'({busy, ovalues}), 32'h80);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      wr_en = ($urandom_range(0, 3) == 0);
      wr_addr = 3'($urandom_range(0, 7));
      wr_data = 7'($urandom);
      step_len = 16'($urandom_range(0, 4));
      if ($urandom_range(0, 15) == 0) last_idx = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 31) == 0) loop_en = ~loop_en;
      start = ($urandom_range(0, 7) == 0);
      stop = ($urandom_range(0, 40) == 0);
      req_valid = ($urandom_range(0, 9) == 0);
      req_sel_pwm = 1'($urandom);
      req_invert = 1'($urandom);
      pwm_period_end = ($urandom_range(0, 5) == 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
